// File: rtl/bitserial_mac_seq_ctrl_pkg.sv
// bitserial_mac_seq_ctrl_pkg: shared state codes and default widths for the bit-serial MAC sequencer
package bitserial_mac_seq_ctrl_pkg;
    localparam int MCAND_W_DEF = 4;
    localparam int MPLR_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int TIMEOUT_DEF = 64;
    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t CLEAR = 3'd1;
    localparam state_t START = 3'd2;
    localparam state_t SHIFT = 3'd3;
    localparam state_t WAIT_DONE = 3'd4;
    localparam state_t OUT = 3'd5;
endpackage

// File: rtl/bitserial_mac_seq_ctrl_feeder.sv
// bitserial_shift_feeder: loadable LSB-first shift register with bit counter and last-bit flag
module bitserial_shift_feeder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             serial_bit,
    output logic             last_bit
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] sr;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
            cnt <= '0;
        end else if (load) begin
            sr <= din;
            cnt <= '0;
        end else if (shift) begin
            sr <= sr >> 1;
            cnt <= cnt + 1'b1;
        end
    end
    assign serial_bit = sr[0];
    assign last_bit = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/bitserial_mac_seq_ctrl.sv
// bitserial_mac_seq_ctrl: sequences one bit-serial multiply-accumulate per operand pair and
// returns the dot-product result and element count when the last pair completes
module bitserial_mac_seq_ctrl
    import bitserial_mac_seq_ctrl_pkg::*;
#(
    parameter int MULTIPLICAND_WIDTH = MCAND_W_DEF,
    parameter int MULTIPLIER_WIDTH = MPLR_W_DEF,
    parameter int ACC_WIDTH = MULTIPLICAND_WIDTH + MULTIPLIER_WIDTH,
    parameter int CNT_WIDTH = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MULTIPLICAND_WIDTH-1:0] in_multiplicand,
    input  logic [MULTIPLIER_WIDTH-1:0]   in_multiplier,
    input  logic                          in_last,
    output logic                          mac_start,
    output logic                          mac_clear_acc,
    output logic [MULTIPLICAND_WIDTH-1:0] mac_multiplicand,
    output logic [MULTIPLIER_WIDTH-1:0]   mac_multiplier,
    output logic                          mac_serial_bit,
    input  logic                          mac_done,
    input  logic [ACC_WIDTH-1:0]          mac_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_result,
    output logic [CNT_WIDTH-1:0]          out_count,
    output logic                          busy,
    output logic                          timeout_err
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    state_t state;
    logic first_flag, last_r, last_bit, ser, accept, feeding, wd_expired;
    logic [CNT_WIDTH-1:0] elem_cnt;
    logic [WDW-1:0] wd_cnt;
    assign accept = in_valid && in_ready;
    assign feeding = state == START || state == SHIFT;
    assign wd_expired = wd_cnt == WDW'(TIMEOUT_CYCLES - 1);
    bitserial_shift_feeder #(.WIDTH(MULTIPLIER_WIDTH)) u_feeder (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .shift     (feeding),
        .din       (in_multiplier),
        .serial_bit(ser),
        .last_bit  (last_bit)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            first_flag <= 1'b1;
            last_r <= 1'b0;
            mac_multiplicand <= '0;
            mac_multiplier <= '0;
            elem_cnt <= '0;
            wd_cnt <= '0;
            out_result <= '0;
            out_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mac_multiplicand <= in_multiplicand;
                    mac_multiplier <= in_multiplier;
                    last_r <= in_last;
                    state <= first_flag ? CLEAR : START;
                end
                CLEAR: state <= START;
                START: state <= SHIFT;
                SHIFT: if (last_bit) state <= WAIT_DONE;
                WAIT_DONE: if (mac_done) begin
                    wd_cnt <= '0;
                    elem_cnt <= elem_cnt + 1'b1;
                    if (last_r) begin
                        out_result <= mac_result;
                        out_count <= elem_cnt + 1'b1;
                        state <= OUT;
                    end else begin
                        first_flag <= 1'b0;
                        state <= IDLE;
                    end
                end else if (wd_expired) begin
                    // watchdog abort drops the whole vector
                    wd_cnt <= '0;
                    timeout_err <= 1'b1;
                    first_flag <= 1'b1;
                    elem_cnt <= '0;
                    state <= IDLE;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                OUT: if (out_ready) begin
                    first_flag <= 1'b1;
                    elem_cnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // strobes are masked during reset so an aborted operation never emits a stray pulse
    assign in_ready = state == IDLE && !rst;
    assign mac_clear_acc = state == CLEAR && !rst;
    assign mac_start = state == START && !rst;
    assign mac_serial_bit = feeding && !rst && ser;
    assign out_valid = state == OUT;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_bitserial_mac_seq_ctrl.sv
// tb_bitserial_mac_seq_ctrl: directed and randomized checks of the sequencer against a
// behavioural bit-serial MAC and a sum-of-products reference
module tb_bitserial_mac_seq_ctrl;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_last, mac_start, mac_clear_acc, mac_serial_bit;
    logic mac_done, out_valid, out_ready, busy, timeout_err;
    logic [3:0] in_multiplicand, in_multiplier, mac_multiplicand, mac_multiplier;
    logic [7:0] mac_result, out_result, out_count;
    int n_cmp = 0, n_err = 0, cyc = 0;
    int n_clr = 0, n_st = 0, clr_cyc = 0, st_cyc = 0, acc_cyc = 0, cap = 0;
    logic [3:0] ser_v;
    logic [15:0] res_q[$];
    bit mac_en = 1'b1;
    logic [7:0] acc;
    logic [3:0] bits, mc;
    int k, dly;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitserial_mac_seq_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier), .in_last(in_last),
        .mac_start(mac_start), .mac_clear_acc(mac_clear_acc),
        .mac_multiplicand(mac_multiplicand), .mac_multiplier(mac_multiplier),
        .mac_serial_bit(mac_serial_bit), .mac_done(mac_done), .mac_result(mac_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_count(out_count), .busy(busy), .timeout_err(timeout_err)
    );

    // behavioural MAC: gathers four serial bits from the start cycle, then signals done after a random delay
    assign mac_done = done_r;
    assign mac_result = acc;
    logic done_r;
    always @(posedge clk) begin
        if (rst) begin
            acc <= 8'h0;
            k <= 0;
            dly <= 0;
            done_r <= 1'b0;
        end else begin
            done_r <= (dly == 1);
            if (dly > 0) dly <= dly - 1;
            if (mac_clear_acc) acc <= 8'h0;
            if (mac_start) begin
                mc <= mac_multiplicand;
                bits <= {3'b0, mac_serial_bit};
                k <= 1;
            end else if (k == 3) begin
                acc <= acc + {4'b0, mc} * {4'b0, mac_serial_bit, bits[2:0]};
                k <= 0;
                dly <= mac_en ? int'($urandom_range(1, 4)) : 0;
            end else if (k > 0) begin
                bits[k[1:0]] <= mac_serial_bit;
                k <= k + 1;
            end
        end
    end

    // observes the values that the next rising edge will register
    always @(negedge clk) begin
        #2;
        if (mac_clear_acc) begin n_clr++; clr_cyc = cyc; end
        if (mac_start) begin
            n_st++;
            st_cyc = cyc;
            ser_v = {3'b0, mac_serial_bit};
            cap = 1;
        end else if (cap > 0 && cap < 4) begin
            ser_v[cap[1:0]] = mac_serial_bit;
            cap++;
        end
        if (in_valid && in_ready) acc_cyc = cyc;
        if (out_valid && out_ready) res_q.push_back({out_count, out_result});
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_multiplicand = a;
        in_multiplier = b;
        in_last = l;
        while (!in_ready && t < 300) begin tick(); t++; end
        if (!in_ready) chk("in_ready_wait", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [7:0] exp_res, input logic [7:0] exp_cnt);
        int t = 0;
        logic [15:0] r;
        while (res_q.size() == 0 && t < 500) begin tick(); t++; end
        if (res_q.size() == 0) chk({tag, "_wait"}, res_q.size(), 1);
        else begin
            r = res_q.pop_front();
            chk({tag, "_res"}, 32'(r[7:0]), 32'(exp_res));
            chk({tag, "_cnt"}, 32'(r[15:8]), 32'(exp_cnt));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int c0, s0, t, len;
        logic [3:0] a, b;
        logic [7:0] sum;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_multiplicand = 4'h0;
        in_multiplier = 4'h0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_strobes", {29'b0, mac_start, mac_clear_acc, mac_serial_bit}, 0);
        chk("rst_operands", {24'b0, mac_multiplicand, mac_multiplier}, 0);

        c0 = n_clr; s0 = n_st;
        send(4'h2, 4'h6, 1'b0);
        send(4'h3, 4'h4, 1'b1);
        wait_result("vec2", 8'h18, 8'd2);
        chk("vec2_clears", n_clr - c0, 1);
        chk("vec2_starts", n_st - s0, 2);
        chk("later_elem_latency", st_cyc - acc_cyc, 1);

        send(4'hF, 4'hF, 1'b1);
        wait_result("single", 8'hE1, 8'd1);
        chk("clear_to_start", st_cyc - clr_cyc, 1);
        chk("first_elem_latency", st_cyc - acc_cyc, 2);

        send(4'h1, 4'hA, 1'b1);
        wait_result("serial", 8'h0A, 8'd1);
        chk("serial_bits", 32'(ser_v), 32'hA);

        out_ready = 1'b0;
        send(4'h7, 4'h3, 1'b1);
        t = 0;
        while (!out_valid && t < 300) begin tick(); t++; end
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_result", 32'(out_result), 32'h15);
            chk("bp_out_count", 32'(out_count), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_accept_valid", 32'(out_valid), 1);
        tick();
        chk("bp_after_valid", 32'(out_valid), 0);
        chk("bp_after_busy", 32'(busy), 0);
        wait_result("bp", 8'h15, 8'd1);

        mac_en = 1'b0;
        send(4'h5, 4'h5, 1'b1);
        t = 0;
        while (!timeout_err && t < 300) begin tick(); t++; end
        chk("to_err", 32'(timeout_err), 1);
        chk("to_latency", cyc - st_cyc, 68);
        chk("to_busy", 32'(busy), 0);
        chk("to_no_output", res_q.size(), 0);
        mac_en = 1'b1;
        send(4'h1, 4'h1, 1'b1);
        wait_result("after_to", 8'h01, 8'd1);
        chk("to_sticky", 32'(timeout_err), 1);

        send(4'h6, 4'h7, 1'b0);
        t = 0;
        while (!mac_start && t < 50) begin tick(); t++; end
        tick();
        rst = 1'b1;
        #1;
        chk("rstmid_cycle_strobes", {30'b0, mac_start, mac_clear_acc}, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_out_valid", 32'(out_valid), 0);
        chk("rstmid_strobes", {29'b0, mac_start, mac_clear_acc, mac_serial_bit}, 0);
        chk("rstmid_timeout_cleared", 32'(timeout_err), 0);
        c0 = n_clr;
        send(4'h2, 4'h3, 1'b1);
        wait_result("after_rst", 8'h06, 8'd1);
        chk("after_rst_clear", n_clr - c0, 1);

        for (int v = 0; v < 15; v++) begin
            len = $urandom_range(1, 5);
            sum = 8'h0;
            for (int e = 0; e < len; e++) begin
                a = 4'($urandom);
                b = 4'($urandom);
                sum = sum + {4'b0, a} * {4'b0, b};
                send(a, b, e == len - 1);
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
            end
            wait_result("rand", sum, 8'(len));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
